// File: rtl/sysarr_pkg.sv
// Shared constants, state encoding and result slicing for the systolic-array result drain.
package sysarr_pkg;
    localparam int N         = 4;
    localparam int CW        = 33;
    localparam int K_LEN     = 4;
    localparam int NUM_RES   = N * N;
    localparam int DRAIN_LAT = K_LEN + 2 * N - 1;
    localparam int IW        = $clog2(NUM_RES);
    localparam int CNT_W     = $clog2(DRAIN_LAT);
    localparam int FLAT_W    = NUM_RES * CW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } state_t;

    // Result i of the row-major flattened accumulator bus (c1 in the low bits).
    function automatic logic [CW-1:0] get_result(input logic [FLAT_W-1:0] flat, input int i);
        return flat[i*CW +: CW];
    endfunction
endpackage

// File: rtl/sysarr_result_drain_if.sv
// Valid/ready result stream from the drain toward writeback/host.
interface sysarr_result_drain_if;
    import sysarr_pkg::*;

    logic [CW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sysarr_result_buf.sv
// Snapshot bank of all PE results, captured in one cycle, with a registered read port.
module sysarr_result_buf
    import sysarr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_capture,
    input  logic [FLAT_W-1:0] i_c_flat,
    input  logic [IW-1:0]     i_rd_idx,
    output logic [CW-1:0]     o_rd_data
);
    logic [CW-1:0] w_slice [NUM_RES];
    logic [CW-1:0] r_bank  [NUM_RES];
    logic [CW-1:0] r_rd_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RES; gi++) begin : g_slice
            assign w_slice[gi] = get_result(i_c_flat, gi);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_RES; i++) begin
                r_bank[i] <= '0;
            end
        end else if (i_capture) begin
            for (int i = 0; i < NUM_RES; i++) begin
                r_bank[i] <= w_slice[i];
            end
        end
    end

    // On capture the bank is not yet written, so result 0 is taken straight from the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else if (i_capture) begin
            r_rd_data <= w_slice[0];
        end else begin
            r_rd_data <= r_bank[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/sysarr_result_drain.sv
// Waits the array drain latency after start, snapshots all results, then streams them out in index order.
module sysarr_result_drain
    import sysarr_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [FLAT_W-1:0]            i_c_flat,
    sysarr_result_drain_if.master        m_out,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_start_drop
);
    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     w_idx_next;
    logic              r_done;
    logic              w_done_next;
    logic              r_start_drop;
    logic              w_start_drop_next;
    logic              w_capture;
    logic              w_valid;
    logic              w_hs;
    logic              w_at_last;
    logic [CW-1:0]     w_rd_data;

    assign w_valid   = (r_state == STREAM);
    assign w_at_last = (r_idx == IW'(NUM_RES - 1));
    assign w_hs      = w_valid && m_out.out_ready;

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_idx_next        = r_idx;
        w_done_next       = 1'b0;
        w_start_drop_next = 1'b0;
        w_capture         = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = WAIT;
                    w_cnt_next   = '0;
                end
            end
            WAIT: begin
                w_start_drop_next = i_start;
                if (r_cnt == CNT_W'(DRAIN_LAT - 1)) begin
                    w_capture    = 1'b1;
                    w_state_next = STREAM;
                    w_idx_next   = '0;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            STREAM: begin
                w_start_drop_next = i_start;
                if (w_hs) begin
                    if (w_at_last) begin
                        w_state_next = IDLE;
                        w_idx_next   = '0;
                        w_done_next  = 1'b1;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_done       <= 1'b0;
            r_start_drop <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_done       <= w_done_next;
            r_start_drop <= w_start_drop_next;
        end
    end

    // Read address is the next index so the registered read lines up with r_idx.
    sysarr_result_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_capture (w_capture),
        .i_c_flat  (i_c_flat),
        .i_rd_idx  (w_idx_next),
        .o_rd_data (w_rd_data)
    );

    assign m_out.out_data  = w_rd_data;
    assign m_out.out_idx   = r_idx;
    assign m_out.out_valid = w_valid;
    assign m_out.out_last  = w_valid && w_at_last;
    assign o_busy          = (r_state != IDLE);
    assign o_done          = r_done;
    assign o_start_drop    = r_start_drop;
endmodule
